riscv_multi_cycle_control: RTL and testbench
============================================

// Module: riscv_multi_cycle_control
// PURPOSE
//  Multi-cycle RISC-V RV32I control FSM: next-generation controller for a shared-memory, multi-cycle core.
//  Sequences fetch/decode/execute/memory/writeback and drives datapath enables and mux selects.
//  Supports memory wait-states (ready handshake), optional BNE, wait timeout, illegal-opcode trap and perf counters.
// PARAMETERS
//  CNT_WIDTH     32  width of cycle_cnt_o / instret_cnt_o
//  MEM_WAIT_EN   1   1: honour mem_ready_i; 0: memory always ready (internal ready = 1)
//  BNE_EN        1   1: funct3=001 (bne) supported; 0: only beq (funct3=000) may be taken
//  WAIT_TIMEOUT  0   0: no timeout; N>0: more than N consecutive stalled cycles -> TRAP
// PORTS
//  clk            in   1   clock; all state updates on rising edge
//  reset          in   1   synchronous, active-high reset
//  op_i           in   7   instruction[6:0] from instruction register
//  funct3_i       in   3   instruction[14:12]
//  zero_i         in   1   ALU zero flag
//  mem_ready_i    in   1   memory access completes this cycle
//  pc_write_o     out  1   load PC from result mux
//  ir_write_o     out  1   load instruction register and old-PC register
//  adr_src_o      out  1   memory address: 0 PC, 1 ALUOut
//  mem_read_o     out  1   memory read request
//  mem_write_o    out  1   memory write request
//  reg_write_o    out  1   register file write enable
//  alu_src_a_o    out  2   00 PC, 01 oldPC, 10 rs1, 11 zero
//  alu_src_b_o    out  2   00 rs2, 01 imm, 10 constant 4
//  alu_op_o       out  3   00x ADD, 010 R-type, 011 I-type, 100 BRANCH (sub)
//  result_src_o   out  2   00 ALUOut reg, 01 memory data, 10 ALU result
//  illegal_o      out  1   sticky trap flag
//  state_o        out  4   current state encoding (debug)
//  cycle_cnt_o    out  CNT_WIDTH  cycles since reset
//  instret_cnt_o  out  CNT_WIDTH  retired instructions
// BEHAVIOUR
//  Reset (clk edge with reset=1): state=FETCH, counters=0, illegal_o=0, wait counter=0.
//  While reset=1, all enables (pc/ir/reg/mem write, mem_read) are forced 0.
//  Outputs are Moore-decoded from state, except pc_write_o/ir_write_o/mem_write_o (gated by ready, branch result).
//  FETCH: mem_read=1, adr=PC, A=PC, B=4, ADD, result=10; ir_write=pc_write=ready; stay until ready -> DECODE.
//  DECODE: A=oldPC, B=imm, ADD (target -> ALUOut). Dispatch on op_i:
//   0000011/0100011 MEMADR; 0110011 EXEC_R; 0010011 EXEC_I; 1100011 BRANCH; 1101111 JAL;
//   1100111 JALR; 0110111 LUI; any other -> TRAP.
//  MEMADR: A=rs1, B=imm, ADD -> MEMREAD (load) else MEMWRITE.
//  MEMREAD: adr=ALUOut, mem_read=1; hold until ready -> MEMWB.   MEMWB: result=01, reg_write=1 -> FETCH.
//  MEMWRITE: adr=ALUOut, mem_write=1 until ready (single-cycle pulse when ready) -> FETCH.
//  EXEC_R: A=rs1, B=rs2, op=010 -> ALUWB.   EXEC_I: A=rs1, B=imm, op=011 -> ALUWB.
//  LUI: A=zero, B=imm, ADD -> ALUWB.   ALUWB: result=00, reg_write=1 -> FETCH.
//  BRANCH: A=rs1, B=rs2, op=100, result=00; pc_write = (f3=000 & zero) | (BNE_EN & f3=001 & ~zero); -> FETCH.
//   Other funct3: not taken, retires normally.
//  JAL: result=00, pc_write=1, A=oldPC, B=4, ADD -> ALUWB (writes link).
//  JALR: A=rs1, B=imm, ADD -> JALR_PC.   JALR_PC: result=00, pc_write=1, A=oldPC, B=4 -> ALUWB.
//  TRAP: illegal_o=1, all enables 0, absorbing until reset.
//  Wait timeout: stalled cycle = FETCH/MEMREAD/MEMWRITE with ready=0; counter resets on ready/state change;
//   count reaching WAIT_TIMEOUT and still stalled -> TRAP next edge.
//  cycle_cnt: +1 every non-reset cycle except in TRAP; wraps modulo 2^CNT_WIDTH.
//  instret: +1 on each transition into FETCH from MEMWB, MEMWRITE, ALUWB, BRANCH; wraps.
//  Cycles/instr with ready=1: R/I/LUI 4, load 5, store 4, branch 3, jal 4, jalr 5.
// STRUCTURE
//  Package riscv_mc_pkg: state enum, opcode constants, alu_op codes, src/result select codes.
//  Sub-module riscv_mc_perf_counters (cycle/instret, CNT_WIDTH, enable inputs).
//  FSM: registered state + combinational next-state/output decode.
// TESTING
//  addi x1,x0,5 with ready=1 -> states F,D,EI,AW; reg_write in cycle 4; instret=1, cycle=4.
//  lw, ready low 3 cycles in MEMREAD -> mem_read held 4 cycles, reg_write once, result_src=01.
//  beq zero=1 / bne zero=1 (BNE_EN=1) -> pc_write 1 / 0 in BRANCH; BNE_EN=0, f3=001, zero=0 -> no pc_write.
//  op_i=0000000 -> TRAP, illegal_o=1, counters frozen; reset -> FETCH, counters 0.
//  WAIT_TIMEOUT=4, ready held 0 in FETCH -> TRAP after 5 stalled cycles; ir_write never asserted.
//  reset asserted in MEMWRITE with ready=1 -> no mem_write that cycle; FETCH next cycle.

Source files
------------

// File: rtl/riscv_mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : riscv_mc_pkg                                               |
// | Purpose : Shared types and encodings for the multi-cycle RV32I       |
// |           control FSM: state enum, opcodes, ALU op and mux selects.  |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
package riscv_mc_pkg;

  // Controller states; the numeric value is visible on state_o for debug.
  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEMADR   = 4'd2,
    ST_MEMREAD  = 4'd3,
    ST_MEMWB    = 4'd4,
    ST_MEMWRITE = 4'd5,
    ST_EXEC_R   = 4'd6,
    ST_EXEC_I   = 4'd7,
    ST_ALUWB    = 4'd8,
    ST_BRANCH   = 4'd9,
    ST_JAL      = 4'd10,
    ST_JALR     = 4'd11,
    ST_JALR_PC  = 4'd12,
    ST_LUI      = 4'd13,
    ST_TRAP     = 4'd14
  } state_t;

  // Major opcodes (instruction[6:0])
  localparam logic [6:0] c_op_load   = 7'b0000011;
  localparam logic [6:0] c_op_store  = 7'b0100011;
  localparam logic [6:0] c_op_rtype  = 7'b0110011;
  localparam logic [6:0] c_op_itype  = 7'b0010011;
  localparam logic [6:0] c_op_branch = 7'b1100011;
  localparam logic [6:0] c_op_jal    = 7'b1101111;
  localparam logic [6:0] c_op_jalr   = 7'b1100111;
  localparam logic [6:0] c_op_lui    = 7'b0110111;

  // Branch funct3 codes
  localparam logic [2:0] c_f3_beq = 3'b000;
  localparam logic [2:0] c_f3_bne = 3'b001;

  // ALU operation requests to the ALU decoder
  localparam logic [2:0] c_alu_add    = 3'b000;
  localparam logic [2:0] c_alu_rtype  = 3'b010;
  localparam logic [2:0] c_alu_itype  = 3'b011;
  localparam logic [2:0] c_alu_branch = 3'b100;

  // ALU source A select
  localparam logic [1:0] c_srca_pc    = 2'b00;
  localparam logic [1:0] c_srca_oldpc = 2'b01;
  localparam logic [1:0] c_srca_rs1   = 2'b10;
  localparam logic [1:0] c_srca_zero  = 2'b11;

  // ALU source B select
  localparam logic [1:0] c_srcb_rs2  = 2'b00;
  localparam logic [1:0] c_srcb_imm  = 2'b01;
  localparam logic [1:0] c_srcb_four = 2'b10;

  // Result mux select
  localparam logic [1:0] c_res_aluout    = 2'b00;
  localparam logic [1:0] c_res_memdata   = 2'b01;
  localparam logic [1:0] c_res_aluresult = 2'b10;

endpackage
`default_nettype wire

// File: rtl/riscv_mc_perf_counters.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : riscv_mc_perf_counters                                     |
// | Purpose : Free-running cycle and retired-instruction counters with   |
// |           independent enables; both wrap modulo 2^CNT_WIDTH.         |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module riscv_mc_perf_counters #(
  parameter int CNT_WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cycle_en,
  input  logic                 instret_en,
  output logic [CNT_WIDTH-1:0] cycle_cnt,
  output logic [CNT_WIDTH-1:0] instret_cnt
);

  // Count enabled cycles and retirements; reset clears both.
  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (cycle_en) begin
        cycle_cnt <= cycle_cnt + CNT_WIDTH'(1);
      end
      if (instret_en) begin
        instret_cnt <= instret_cnt + CNT_WIDTH'(1);
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/riscv_multi_cycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : riscv_multi_cycle_control                                  |
// | Purpose : Multi-cycle RV32I control FSM for a shared-memory core:    |
// |           sequences fetch/decode/execute/memory/writeback, handles   |
// |           memory wait states, stall timeout, illegal-op trap and     |
// |           performance counters.                                      |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module riscv_multi_cycle_control
  import riscv_mc_pkg::*;
#(
  parameter int CNT_WIDTH    = 32,
  parameter int MEM_WAIT_EN  = 1,
  parameter int BNE_EN       = 1,
  parameter int WAIT_TIMEOUT = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [6:0]           op_i,
  input  logic [2:0]           funct3_i,
  input  logic                 zero_i,
  input  logic                 mem_ready_i,
  output logic                 pc_write_o,
  output logic                 ir_write_o,
  output logic                 adr_src_o,
  output logic                 mem_read_o,
  output logic                 mem_write_o,
  output logic                 reg_write_o,
  output logic [1:0]           alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [2:0]           alu_op_o,
  output logic [1:0]           result_src_o,
  output logic                 illegal_o,
  output logic [3:0]           state_o,
  output logic [CNT_WIDTH-1:0] cycle_cnt_o,
  output logic [CNT_WIDTH-1:0] instret_cnt_o
);

  state_t state;
  state_t next_state;
  logic   ready;
  logic   timeout;
  logic   branch_taken;
  logic   pc_write_raw;
  logic   ir_write_raw;
  logic   mem_read_raw;
  logic   mem_write_raw;
  logic   reg_write_raw;
  logic   retire;
  logic   count_cycle;

  // With wait states disabled the memory is treated as always ready.
  assign ready = (MEM_WAIT_EN == 0) ? 1'b1 : mem_ready_i;

  assign branch_taken = ((funct3_i == c_f3_beq) && zero_i) ||
                        ((BNE_EN != 0) && (funct3_i == c_f3_bne) && !zero_i);

  generate
    if (WAIT_TIMEOUT > 0) begin : g_timeout
      localparam int              WAIT_W       = $clog2(WAIT_TIMEOUT + 1);
      localparam logic [WAIT_W-1:0] c_wait_limit = WAIT_W'(WAIT_TIMEOUT);
      logic              stalled;
      logic [WAIT_W-1:0] wait_cnt;

      assign stalled = !ready && ((state == ST_FETCH) || (state == ST_MEMREAD) ||
                                  (state == ST_MEMWRITE));
      // Once the limit has already been reached, one more stalled cycle traps.
      assign timeout = stalled && (wait_cnt == c_wait_limit);

      // Count consecutive stalled cycles; any progress or trap clears it.
      always_ff @(posedge clk) begin
        if (reset) begin
          wait_cnt <= '0;
        end else if (stalled && !timeout) begin
          wait_cnt <= wait_cnt + WAIT_W'(1);
        end else begin
          wait_cnt <= '0;
        end
      end
    end else begin : g_no_timeout
      assign timeout = 1'b0;
    end
  endgenerate

  // State register and sticky illegal flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_FETCH;
      illegal_o <= 1'b0;
    end else begin
      state <= next_state;
      if (next_state == ST_TRAP) begin
        illegal_o <= 1'b1;
      end
    end
  end

  // Next-state and Moore output decode; enables are gated by ready/branch.
  always_comb begin
    next_state    = state;
    pc_write_raw  = 1'b0;
    ir_write_raw  = 1'b0;
    mem_read_raw  = 1'b0;
    mem_write_raw = 1'b0;
    reg_write_raw = 1'b0;
    adr_src_o     = 1'b0;
    alu_src_a_o   = c_srca_pc;
    alu_src_b_o   = c_srcb_rs2;
    alu_op_o      = c_alu_add;
    result_src_o  = c_res_aluout;
    case (state)
      ST_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b_o  = c_srcb_four;
        result_src_o = c_res_aluresult;
        ir_write_raw = ready;
        pc_write_raw = ready;
        if (ready) next_state = ST_DECODE;
      end
      ST_DECODE: begin
        alu_src_a_o = c_srca_oldpc;
        alu_src_b_o = c_srcb_imm;
        case (op_i)
          c_op_load, c_op_store: next_state = ST_MEMADR;
          c_op_rtype:            next_state = ST_EXEC_R;
          c_op_itype:            next_state = ST_EXEC_I;
          c_op_branch:           next_state = ST_BRANCH;
          c_op_jal:              next_state = ST_JAL;
          c_op_jalr:             next_state = ST_JALR;
          c_op_lui:              next_state = ST_LUI;
          default:               next_state = ST_TRAP;
        endcase
      end
      ST_MEMADR: begin
        alu_src_a_o = c_srca_rs1;
        alu_src_b_o = c_srcb_imm;
        next_state  = (op_i == c_op_load) ? ST_MEMREAD : ST_MEMWRITE;
      end
      ST_MEMREAD: begin
        adr_src_o    = 1'b1;
        mem_read_raw = 1'b1;
        if (ready) next_state = ST_MEMWB;
      end
      ST_MEMWB: begin
        result_src_o  = c_res_memdata;
        reg_write_raw = 1'b1;
        next_state    = ST_FETCH;
      end
      ST_MEMWRITE: begin
        adr_src_o     = 1'b1;
        mem_write_raw = ready;
        if (ready) next_state = ST_FETCH;
      end
      ST_EXEC_R: begin
        alu_src_a_o = c_srca_rs1;
        alu_src_b_o = c_srcb_rs2;
        alu_op_o    = c_alu_rtype;
        next_state  = ST_ALUWB;
      end
      ST_EXEC_I: begin
        alu_src_a_o = c_srca_rs1;
        alu_src_b_o = c_srcb_imm;
        alu_op_o    = c_alu_itype;
        next_state  = ST_ALUWB;
      end
      ST_LUI: begin
        alu_src_a_o = c_srca_zero;
        alu_src_b_o = c_srcb_imm;
        next_state  = ST_ALUWB;
      end
      ST_ALUWB: begin
        reg_write_raw = 1'b1;
        next_state    = ST_FETCH;
      end
      ST_BRANCH: begin
        alu_src_a_o  = c_srca_rs1;
        alu_src_b_o  = c_srcb_rs2;
        alu_op_o     = c_alu_branch;
        pc_write_raw = branch_taken;
        next_state   = ST_FETCH;
      end
      ST_JAL: begin
        pc_write_raw = 1'b1;
        alu_src_a_o  = c_srca_oldpc;
        alu_src_b_o  = c_srcb_four;
        next_state   = ST_ALUWB;
      end
      ST_JALR: begin
        alu_src_a_o = c_srca_rs1;
        alu_src_b_o = c_srcb_imm;
        next_state  = ST_JALR_PC;
      end
      ST_JALR_PC: begin
        pc_write_raw = 1'b1;
        alu_src_a_o  = c_srca_oldpc;
        alu_src_b_o  = c_srcb_four;
        next_state   = ST_ALUWB;
      end
      ST_TRAP: begin
        next_state = ST_TRAP;
      end
      default: begin
        next_state = ST_TRAP;
      end
    endcase
    if (timeout) next_state = ST_TRAP;
  end

  assign pc_write_o  = pc_write_raw  & ~reset;
  assign ir_write_o  = ir_write_raw  & ~reset;
  assign mem_read_o  = mem_read_raw  & ~reset;
  assign mem_write_o = mem_write_raw & ~reset;
  assign reg_write_o = reg_write_raw & ~reset;
  assign state_o     = state;

  assign count_cycle = (state != ST_TRAP);
  assign retire      = (next_state == ST_FETCH) &&
                       ((state == ST_MEMWB) || (state == ST_MEMWRITE) ||
                        (state == ST_ALUWB) || (state == ST_BRANCH));

  riscv_mc_perf_counters #(
    .CNT_WIDTH(CNT_WIDTH)
  ) u_perf (
    .clk        (clk),
    .reset      (reset),
    .cycle_en   (count_cycle),
    .instret_en (retire),
    .cycle_cnt  (cycle_cnt_o),
    .instret_cnt(instret_cnt_o)
  );

endmodule
`default_nettype wire

// File: tb/tb_riscv_multi_cycle_control.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module  : tb_riscv_multi_cycle_control                               |
// | Purpose : Self-checking bench for the multi-cycle control FSM.       |
// |           dut_a: wait states on, BNE on, timeout 4.                  |
// |           dut_b: wait states off, BNE off, no timeout.               |
// | Revision: 1.0  initial release                                       |
// +----------------------------------------------------------------------+
module tb_riscv_multi_cycle_control;
  import riscv_mc_pkg::*;

  localparam int CW  = 32;
  localparam int DC  = -1;  // select field not constrained in this state
  localparam int ADD = 8;   // ALU op 00x

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'b0110011;
  logic [2:0] funct3 = 3'b000;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b1;

  logic          a_pc_write, a_ir_write, a_adr_src, a_mem_read, a_mem_write, a_reg_write, a_illegal;
  logic [1:0]    a_src_a, a_src_b, a_result_src;
  logic [2:0]    a_alu_op;
  logic [3:0]    a_state;
  logic [CW-1:0] a_cycle, a_instret;
  logic          b_pc_write, b_ir_write, b_adr_src, b_mem_read, b_mem_write, b_reg_write, b_illegal;
  logic [1:0]    b_src_a, b_src_b, b_result_src;
  logic [2:0]    b_alu_op;
  logic [3:0]    b_state;
  logic [CW-1:0] b_cycle, b_instret;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_multi_cycle_control #(.CNT_WIDTH(CW), .MEM_WAIT_EN(1), .BNE_EN(1), .WAIT_TIMEOUT(4)) dut_a (
    .clk(clk), .reset(reset), .op_i(op), .funct3_i(funct3), .zero_i(zero), .mem_ready_i(mem_ready),
    .pc_write_o(a_pc_write), .ir_write_o(a_ir_write), .adr_src_o(a_adr_src), .mem_read_o(a_mem_read),
    .mem_write_o(a_mem_write), .reg_write_o(a_reg_write), .alu_src_a_o(a_src_a), .alu_src_b_o(a_src_b),
    .alu_op_o(a_alu_op), .result_src_o(a_result_src), .illegal_o(a_illegal), .state_o(a_state),
    .cycle_cnt_o(a_cycle), .instret_cnt_o(a_instret));

  riscv_multi_cycle_control #(.CNT_WIDTH(CW), .MEM_WAIT_EN(0), .BNE_EN(0), .WAIT_TIMEOUT(0)) dut_b (
    .clk(clk), .reset(reset), .op_i(op), .funct3_i(funct3), .zero_i(zero), .mem_ready_i(mem_ready),
    .pc_write_o(b_pc_write), .ir_write_o(b_ir_write), .adr_src_o(b_adr_src), .mem_read_o(b_mem_read),
    .mem_write_o(b_mem_write), .reg_write_o(b_reg_write), .alu_src_a_o(b_src_a), .alu_src_b_o(b_src_b),
    .alu_op_o(b_alu_op), .result_src_o(b_result_src), .illegal_o(b_illegal), .state_o(b_state),
    .cycle_cnt_o(b_cycle), .instret_cnt_o(b_instret));

  // One expected cycle class of an instruction. rdy: phase waits for memory.
  // val/care pack {adr_src, result_src, alu_src_a, alu_src_b, alu_op}.
  typedef struct {
    state_t     st;
    bit         rdy;
    bit         rw;
    bit         pw;
    bit         mr;
    bit         mw;
    logic [9:0] val;
    logic [9:0] care;
  } phase_t;

  function automatic phase_t ph(state_t st, bit rdy, bit rw, bit pw, bit mr, bit mw,
                                int adr, int res, int sa, int sb, int aop);
    phase_t p;
    p.st = st; p.rdy = rdy; p.rw = rw; p.pw = pw; p.mr = mr; p.mw = mw;
    p.val = '0; p.care = '0;
    if (adr >= 0) begin p.val[9]   = adr[0];   p.care[9]   = 1'b1;  end
    if (res >= 0) begin p.val[8:7] = res[1:0]; p.care[8:7] = 2'b11; end
    if (sa >= 0)  begin p.val[6:5] = sa[1:0];  p.care[6:5] = 2'b11; end
    if (sb >= 0)  begin p.val[4:3] = sb[1:0];  p.care[4:3] = 2'b11; end
    if (aop == ADD) begin
      p.val[2:0] = 3'b000; p.care[2:0] = 3'b110;
    end else if (aop >= 0) begin
      p.val[2:0] = aop[2:0]; p.care[2:0] = 3'b111;
    end
    return p;
  endfunction

  // Reference: instruction -> sequence of cycle classes (dut_a configuration).
  function automatic void build_plan(input logic [6:0] o, input logic [2:0] f3, input logic z,
                                     output phase_t q[$]);
    bit taken;
    phase_t aluwb;
    taken = ((f3 == 3'b000) && z) || ((f3 == 3'b001) && !z);
    aluwb = ph(ST_ALUWB, 0, 1, 0, 0, 0, DC, 0, DC, DC, DC);
    q = {};
    q.push_back(ph(ST_FETCH, 1, 0, 1, 1, 0, 0, 2, 0, 2, ADD));
    q.push_back(ph(ST_DECODE, 0, 0, 0, 0, 0, DC, DC, 1, 1, ADD));
    case (o)
      7'b0000011: begin
        q.push_back(ph(ST_MEMADR, 0, 0, 0, 0, 0, DC, DC, 2, 1, ADD));
        q.push_back(ph(ST_MEMREAD, 1, 0, 0, 1, 0, 1, DC, DC, DC, DC));
        q.push_back(ph(ST_MEMWB, 0, 1, 0, 0, 0, DC, 1, DC, DC, DC));
      end
      7'b0100011: begin
        q.push_back(ph(ST_MEMADR, 0, 0, 0, 0, 0, DC, DC, 2, 1, ADD));
        q.push_back(ph(ST_MEMWRITE, 1, 0, 0, 0, 1, 1, DC, DC, DC, DC));
      end
      7'b0110011: begin q.push_back(ph(ST_EXEC_R, 0, 0, 0, 0, 0, DC, DC, 2, 0, 2));   q.push_back(aluwb); end
      7'b0010011: begin q.push_back(ph(ST_EXEC_I, 0, 0, 0, 0, 0, DC, DC, 2, 1, 3));   q.push_back(aluwb); end
      7'b0110111: begin q.push_back(ph(ST_LUI, 0, 0, 0, 0, 0, DC, DC, 3, 1, ADD));    q.push_back(aluwb); end
      7'b1100011: q.push_back(ph(ST_BRANCH, 0, 0, taken, 0, 0, DC, 0, 2, 0, 4));
      7'b1101111: begin q.push_back(ph(ST_JAL, 0, 0, 1, 0, 0, DC, 0, 1, 2, ADD));     q.push_back(aluwb); end
      7'b1100111: begin
        q.push_back(ph(ST_JALR, 0, 0, 0, 0, 0, DC, DC, 2, 1, ADD));
        q.push_back(ph(ST_JALR_PC, 0, 0, 1, 0, 0, DC, 0, 1, 2, DC));
        q.push_back(aluwb);
      end
      default: ;
    endcase
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; mem_ready = 1'b1; op = 7'b0110011;
    @(negedge clk); #1;
    checks++;
    if ({a_pc_write, a_ir_write, a_reg_write, a_mem_read, a_mem_write} !== 5'b0) begin
      errors++; $display("FAIL reset_enables_a: got %b expected 00000",
                         {a_pc_write, a_ir_write, a_reg_write, a_mem_read, a_mem_write});
    end
    checks++;
    if ({b_pc_write, b_ir_write, b_reg_write, b_mem_read, b_mem_write} !== 5'b0) begin
      errors++; $display("FAIL reset_enables_b: got %b expected 00000",
                         {b_pc_write, b_ir_write, b_reg_write, b_mem_read, b_mem_write});
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (a_state !== ST_FETCH || a_cycle !== 0 || a_instret !== 0 || a_illegal !== 1'b0) begin
      errors++; $display("FAIL reset_state_a: got state=%0d cyc=%0d ret=%0d ill=%b expected 0 0 0 0",
                         a_state, a_cycle, a_instret, a_illegal);
    end
    checks++;
    if (b_state !== ST_FETCH || b_cycle !== 0 || b_instret !== 0 || b_illegal !== 1'b0) begin
      errors++; $display("FAIL reset_state_b: got state=%0d cyc=%0d ret=%0d ill=%b expected 0 0 0 0",
                         b_state, b_cycle, b_instret, b_illegal);
    end
  endtask

  task automatic test_addi();
    state_t seq [4];
    seq = '{ST_FETCH, ST_DECODE, ST_EXEC_I, ST_ALUWB};
    do_reset();
    op = 7'b0010011; funct3 = 3'b000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i > 0) @(negedge clk);
      #1;
      checks++;
      if (a_state !== seq[i] || a_reg_write !== (i == 3)) begin
        errors++; $display("FAIL addi_cycle%0d: got state=%0d rw=%b expected state=%0d rw=%b",
                           i + 1, a_state, a_reg_write, seq[i], (i == 3));
      end
    end
    @(negedge clk); #1;
    checks++;
    if (a_instret !== 1 || a_cycle !== 4 || a_state !== ST_FETCH) begin
      errors++; $display("FAIL addi_counters: got ret=%0d cyc=%0d state=%0d expected 1 4 0",
                         a_instret, a_cycle, a_state);
    end
  endtask

  task automatic test_lw_wait();
    int rd_cnt = 0;
    int rw_cnt = 0;
    do_reset();
    op = 7'b0000011;
    // c0 F, c1 D, c2 MEMADR, c3..c5 MEMREAD stalled, c6 MEMREAD ready, c7 MEMWB, c8 F
    for (int c = 0; c <= 8; c++) begin
      if (c > 0) @(negedge clk);
      mem_ready = !(c >= 3 && c <= 5);
      #1;
      if (c >= 1 && c <= 7 && a_mem_read) rd_cnt++;
      if (a_reg_write) rw_cnt++;
      if (c == 6) begin
        checks++;
        if (a_state !== ST_MEMREAD) begin
          errors++; $display("FAIL lw_hold_state: got %0d expected %0d", a_state, ST_MEMREAD);
        end
      end
      if (c == 7) begin
        checks++;
        if (a_state !== ST_MEMWB || a_reg_write !== 1'b1 || a_result_src !== 2'b01) begin
          errors++; $display("FAIL lw_writeback: got state=%0d rw=%b res=%b expected %0d 1 01",
                             a_state, a_reg_write, a_result_src, ST_MEMWB);
        end
      end
    end
    checks++;
    if (rd_cnt != 4) begin
      errors++; $display("FAIL lw_mem_read_cycles: got %0d expected 4", rd_cnt);
    end
    checks++;
    if (rw_cnt != 1) begin
      errors++; $display("FAIL lw_reg_write_count: got %0d expected 1", rw_cnt);
    end
    checks++;
    if (a_instret !== 1 || a_cycle !== 8) begin
      errors++; $display("FAIL lw_counters: got ret=%0d cyc=%0d expected 1 8", a_instret, a_cycle);
    end
  endtask

  task automatic test_branch();
    logic [2:0] f3s [3];
    bit zs [3];
    bit ea [3];
    bit eb [3];
    f3s = '{3'b000, 3'b001, 3'b001};
    zs  = '{1'b1, 1'b1, 1'b0};
    ea  = '{1'b1, 1'b0, 1'b1};
    eb  = '{1'b1, 1'b0, 1'b0};
    do_reset();
    op = 7'b1100011; mem_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      funct3 = f3s[k]; zero = zs[k];
      @(negedge clk); @(negedge clk); #1;  // F, D, now BRANCH
      checks++;
      if (a_state !== ST_BRANCH || a_pc_write !== ea[k]) begin
        errors++; $display("FAIL branch_a%0d: got state=%0d pw=%b expected %0d %b",
                           k, a_state, a_pc_write, ST_BRANCH, ea[k]);
      end
      checks++;
      if (b_state !== ST_BRANCH || b_pc_write !== eb[k]) begin
        errors++; $display("FAIL branch_b%0d: got state=%0d pw=%b expected %0d %b",
                           k, b_state, b_pc_write, ST_BRANCH, eb[k]);
      end
      @(negedge clk);
    end
    #1;
    checks++;
    if (a_instret !== 3 || a_cycle !== 9 || b_instret !== 3 || b_cycle !== 9) begin
      errors++; $display("FAIL branch_counters: got a=%0d/%0d b=%0d/%0d expected 3/9 3/9",
                         a_instret, a_cycle, b_instret, b_cycle);
    end
  endtask

  task automatic test_trap();
    do_reset();
    op = 7'b0000000; mem_ready = 1'b1;
    #1;
    checks++;
    if (a_state !== ST_FETCH) begin
      errors++; $display("FAIL trap_fetch: got %0d expected %0d", a_state, ST_FETCH);
    end
    @(negedge clk); #1;
    checks++;
    if (a_state !== ST_DECODE) begin
      errors++; $display("FAIL trap_decode: got %0d expected %0d", a_state, ST_DECODE);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      mem_ready = 1'($urandom_range(0, 1));
      zero      = 1'($urandom_range(0, 1));
      #1;
      checks++;
      if (a_state !== ST_TRAP || a_illegal !== 1'b1) begin
        errors++; $display("FAIL trap_state%0d: got state=%0d ill=%b expected %0d 1",
                           i, a_state, a_illegal, ST_TRAP);
      end
      checks++;
      if ({a_pc_write, a_ir_write, a_reg_write, a_mem_read, a_mem_write} !== 5'b0) begin
        errors++; $display("FAIL trap_enables%0d: got %b expected 00000", i,
                           {a_pc_write, a_ir_write, a_reg_write, a_mem_read, a_mem_write});
      end
      checks++;
      if (a_cycle !== 2 || a_instret !== 0) begin
        errors++; $display("FAIL trap_frozen%0d: got cyc=%0d ret=%0d expected 2 0", i, a_cycle, a_instret);
      end
    end
    do_reset(); #1;
    checks++;
    if (a_state !== ST_FETCH || a_illegal !== 1'b0 || a_cycle !== 0 || a_instret !== 0) begin
      errors++; $display("FAIL trap_release: got state=%0d ill=%b cyc=%0d ret=%0d expected 0 0 0 0",
                         a_state, a_illegal, a_cycle, a_instret);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    op = 7'b0010011; mem_ready = 1'b0;
    for (int c = 0; c < 5; c++) begin
      if (c > 0) @(negedge clk);
      #1;
      checks++;
      if (a_state !== ST_FETCH || a_ir_write !== 1'b0 || a_pc_write !== 1'b0) begin
        errors++; $display("FAIL timeout_stall%0d: got state=%0d ir=%b pw=%b expected %0d 0 0",
                           c + 1, a_state, a_ir_write, a_pc_write, ST_FETCH);
      end
    end
    @(negedge clk); #1;
    checks++;
    if (a_state !== ST_TRAP || a_illegal !== 1'b1 || a_ir_write !== 1'b0 || a_cycle !== 5) begin
      errors++; $display("FAIL timeout_trap: got state=%0d ill=%b ir=%b cyc=%0d expected %0d 1 0 5",
                         a_state, a_illegal, a_ir_write, a_cycle, ST_TRAP);
    end
    mem_ready = 1'b1;
  endtask

  task automatic test_reset_memwrite();
    do_reset();
    op = 7'b0100011; mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);  // F, D, MEMADR done
    reset = 1'b1; #1;
    checks++;
    if (a_state !== ST_MEMWRITE || a_mem_write !== 1'b0) begin
      errors++; $display("FAIL reset_in_memwrite: got state=%0d mw=%b expected %0d 0",
                         a_state, a_mem_write, ST_MEMWRITE);
    end
    @(negedge clk); reset = 1'b0; #1;
    checks++;
    if (a_state !== ST_FETCH || a_instret !== 0 || a_cycle !== 0) begin
      errors++; $display("FAIL reset_after_memwrite: got state=%0d ret=%0d cyc=%0d expected 0 0 0",
                         a_state, a_instret, a_cycle);
    end
  endtask

  task automatic test_random();
    phase_t     plan [$];
    phase_t     p;
    logic [6:0] ops [8];
    int         exp_cycle;
    int         exp_instret;
    int         stalls;
    logic [4:0] act_en, exp_en, en_care;
    logic [9:0] act_f;
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b1100111, 7'b0110111};
    do_reset();
    exp_cycle = 0; exp_instret = 0;
    for (int n = 0; n < 60; n++) begin
      op     = ops[$urandom_range(0, 7)];
      funct3 = 3'($urandom_range(0, 7));
      zero   = 1'($urandom_range(0, 1));
      build_plan(op, funct3, zero, plan);
      for (int k = 0; k < plan.size(); k++) begin
        p = plan[k];
        stalls = p.rdy ? $urandom_range(0, 3) : 0;
        for (int s = 0; s <= stalls; s++) begin
          mem_ready = p.rdy ? (s == stalls) : 1'($urandom_range(0, 1));
          #1;
          if (k == 0 && s == 0) begin
            checks++;
            if (a_cycle !== 32'(exp_cycle) || a_instret !== 32'(exp_instret)) begin
              errors++; $display("FAIL random_counters n=%0d: got cyc=%0d ret=%0d expected %0d %0d",
                                 n, a_cycle, a_instret, exp_cycle, exp_instret);
            end
          end
          exp_en  = {(p.st == ST_FETCH) && (!p.rdy || mem_ready), p.pw && (!p.rdy || mem_ready),
                     p.rw, p.mr, p.mw && (!p.rdy || mem_ready)};
          en_care = {4'b1111, !(p.mw && p.rdy && !mem_ready)};
          act_en  = {a_ir_write, a_pc_write, a_reg_write, a_mem_read, a_mem_write};
          act_f   = {a_adr_src, a_result_src, a_src_a, a_src_b, a_alu_op};
          checks++;
          if (a_state !== p.st || ((act_en ^ exp_en) & en_care) != 0 || ((act_f ^ p.val) & p.care) != 0) begin
            errors++;
            $display("FAIL random n=%0d op=%b ph=%0d: got state=%0d en=%b sel=%b expected state=%0d en=%b sel=%b care=%b",
                     n, op, k, a_state, act_en, act_f, p.st, exp_en, p.val, p.care);
          end
          @(negedge clk);
          exp_cycle++;
        end
      end
      exp_instret++;
    end
    #1;
    checks++;
    if (a_cycle !== 32'(exp_cycle) || a_instret !== 32'(exp_instret)) begin
      errors++; $display("FAIL random_final_counters: got cyc=%0d ret=%0d expected %0d %0d",
                         a_cycle, a_instret, exp_cycle, exp_instret);
    end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_lw_wait();
    test_branch();
    test_trap();
    test_timeout();
    test_reset_memwrite();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
